// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_ctrl_pkg;

  // Sequencer states; the block is stalled in every state except ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } trap_state_t;

  // Source of the mtval value latched when a trap is accepted.
  typedef enum logic [1:0] {
    TVAL_ZERO,
    TVAL_INST,
    TVAL_BADADDR,
    TVAL_PC
  } tval_sel_t;

  // Bit positions inside the commit-stage exception vector.
  localparam int EX_ILLEGAL       = 0;
  localparam int EX_INST_MISALIGN = 1;
  localparam int EX_ECALL         = 2;
  localparam int EX_EBREAK        = 3;
  localparam int EX_ST_MISALIGN   = 4;
  localparam int EX_LD_MISALIGN   = 5;

  // Exception codes as written to mcause.
  localparam logic [31:0] CAUSE_ILLEGAL       = 32'd2;
  localparam logic [31:0] CAUSE_INST_MISALIGN = 32'd0;
  localparam logic [31:0] CAUSE_ECALL         = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK        = 32'd3;
  localparam logic [31:0] CAUSE_ST_MISALIGN   = 32'd6;
  localparam logic [31:0] CAUSE_LD_MISALIGN   = 32'd4;
  // Machine timer interrupt code; the interrupt flag (MSB) is added by the encoder
  // so the value stays correct for any XLEN.
  localparam logic [31:0] CAUSE_MTI           = 32'd7;

endpackage

// File: rtl/trap_prio_enc.sv
// Picks the single highest-priority trap source: exceptions (lowest bit first), then interrupt.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is used.
module trap_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      ex_vec_i,
  input  logic            int_pend_i,
  output logic            take_o,
  output logic            is_int_o,
  output logic [XLEN-1:0] cause_o,
  output logic [1:0]      tval_sel_o
);

  // Fixed priority chain: an exception always beats the interrupt.
  always_comb begin
    take_o     = 1'b1;
    is_int_o   = 1'b0;
    cause_o    = '0;
    tval_sel_o = TVAL_ZERO;
    if (ex_vec_i[EX_ILLEGAL]) begin
      cause_o    = XLEN'(CAUSE_ILLEGAL);
      tval_sel_o = TVAL_INST;
    end else if (ex_vec_i[EX_INST_MISALIGN]) begin
      cause_o    = XLEN'(CAUSE_INST_MISALIGN);
      tval_sel_o = TVAL_BADADDR;
    end else if (ex_vec_i[EX_ECALL]) begin
      cause_o    = XLEN'(CAUSE_ECALL);
      tval_sel_o = TVAL_ZERO;
    end else if (ex_vec_i[EX_EBREAK]) begin
      cause_o    = XLEN'(CAUSE_EBREAK);
      tval_sel_o = TVAL_PC;
    end else if (ex_vec_i[EX_ST_MISALIGN]) begin
      cause_o    = XLEN'(CAUSE_ST_MISALIGN);
      tval_sel_o = TVAL_BADADDR;
    end else if (ex_vec_i[EX_LD_MISALIGN]) begin
      cause_o    = XLEN'(CAUSE_LD_MISALIGN);
      tval_sel_o = TVAL_BADADDR;
    end else if (int_pend_i) begin
      is_int_o   = 1'b1;
      cause_o    = {1'b1, (XLEN-1)'(CAUSE_MTI)};
      tval_sel_o = TVAL_ZERO;
    end else begin
      take_o     = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: accept at commit, drain pipe, pulse CSR, redirect fetch.
// Latency: accept N, DRAIN N+1.., COMMIT one cycle, REDIRECT until fetch ready (min 4 cycles to IDLE).
// Backpressure: holds redirect valid/PC stable until i_redirect_ready; stalls commit/fetch meanwhile.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 8,
  parameter int VECTORED  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic [5:0]      i_ex_vec,
  input  logic            i_int_pend,
  input  logic            i_mret,
  input  logic            i_pipe_empty,
  input  logic [XLEN-1:0] i_tvec,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_redirect_ready,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_trap_take,
  output logic            o_mret_take,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_tval,
  output logic [XLEN-1:0] o_trap_pc,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  localparam int              CNT_W    = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0]  MTI_VEC_OFF = XLEN'(4 * CAUSE_MTI);

  trap_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            is_mret_q;
  logic            is_int_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] trap_pc_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            enc_take;
  logic            enc_is_int;
  logic [XLEN-1:0] enc_cause;
  logic [1:0]      enc_tval_sel;
  logic            accept;
  logic            drain_done;
  logic [XLEN-1:0] tval_d;
  logic [XLEN-1:0] redirect_pc_d;

  trap_prio_enc #(.XLEN(XLEN)) u_prio (
    .ex_vec_i   (i_ex_vec),
    .int_pend_i (i_int_pend),
    .take_o     (enc_take),
    .is_int_o   (enc_is_int),
    .cause_o    (enc_cause),
    .tval_sel_o (enc_tval_sel)
  );

  // Acceptance and drain-exit conditions; reset gates acceptance so flush stays low in reset.
  always_comb begin
    accept     = i_rst && (state_q == ST_IDLE) && i_valid &&
                 ((|i_ex_vec) || i_int_pend || i_mret);
    drain_done = i_pipe_empty || (cnt_q == CNT_LAST);
  end

  // mtval source select and fetch target for the COMMIT exit edge.
  always_comb begin
    tval_d = '0;
    case (enc_tval_sel)
      TVAL_INST:    tval_d = XLEN'(i_inst);
      TVAL_BADADDR: tval_d = i_badaddr;
      TVAL_PC:      tval_d = i_pc;
      default:      tval_d = '0;
    endcase
    if (is_mret_q) begin
      redirect_pc_d = i_epc & ALIGN_MASK;
    end else if ((VECTORED != 0) && is_int_q) begin
      redirect_pc_d = (i_tvec & ALIGN_MASK) + MTI_VEC_OFF;
    end else begin
      redirect_pc_d = i_tvec & ALIGN_MASK;
    end
  end

  // Sequencer FSM with latched trap state; reset abandons any trap in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_mret_q     <= 1'b0;
      is_int_q      <= 1'b0;
      cause_q       <= '0;
      tval_q        <= '0;
      trap_pc_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_DRAIN;
            if (enc_take) begin
              is_mret_q <= 1'b0;
              is_int_q  <= enc_is_int;
              cause_q   <= enc_cause;
              tval_q    <= tval_d;
              trap_pc_q <= i_pc;
            end else begin
              // MRET only records its kind; CSR-visible trap values stay as they were.
              is_mret_q <= 1'b1;
              is_int_q  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_COMMIT;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          redirect_pc_q <= redirect_pc_d;
          state_q       <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (i_redirect_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state and latched values.
  always_comb begin
    o_stall          = (state_q != ST_IDLE);
    o_flush          = accept || (state_q == ST_DRAIN);
    o_trap_take      = (state_q == ST_COMMIT) && !is_mret_q;
    o_mret_take      = (state_q == ST_COMMIT) && is_mret_q;
    o_redirect_valid = (state_q == ST_REDIRECT);
    o_cause          = cause_q;
    o_tval           = tval_q;
    o_trap_pc        = trap_pc_q;
    o_redirect_pc    = redirect_pc_q;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: scoreboard of expected trap/MRET sequences checked at COMMIT and at redirect handshake.
module tb_trap_ctrl;

  localparam int XLEN      = 32;
  localparam int DRAIN_MAX = 8;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_valid = 1'b0;
  logic [31:0]     i_pc = '0;
  logic [31:0]     i_inst = '0;
  logic [31:0]     i_badaddr = '0;
  logic [5:0]      i_ex_vec = '0;
  logic            i_int_pend = 1'b0;
  logic            i_mret = 1'b0;
  logic            i_pipe_empty = 1'b1;
  logic [31:0]     i_tvec = 32'h200;
  logic [31:0]     i_epc = '0;
  logic            i_redirect_ready = 1'b1;
  logic            o_stall, o_flush, o_trap_take, o_mret_take, o_redirect_valid;
  logic [31:0]     o_cause, o_tval, o_trap_pc, o_redirect_pc;

  trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX), .VECTORED(1)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_valid          (i_valid),
    .i_pc             (i_pc),
    .i_inst           (i_inst),
    .i_badaddr        (i_badaddr),
    .i_ex_vec         (i_ex_vec),
    .i_int_pend       (i_int_pend),
    .i_mret           (i_mret),
    .i_pipe_empty     (i_pipe_empty),
    .i_tvec           (i_tvec),
    .i_epc            (i_epc),
    .i_redirect_ready (i_redirect_ready),
    .o_stall          (o_stall),
    .o_flush          (o_flush),
    .o_trap_take      (o_trap_take),
    .o_mret_take      (o_mret_take),
    .o_cause          (o_cause),
    .o_tval           (o_tval),
    .o_trap_pc        (o_trap_pc),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] tpc;
    logic [31:0] rpc;
    int          commit_cyc;
    int          redir_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, o_stall, 0);
    chk({tag, "_flush"}, o_flush, 0);
    chk({tag, "_trap_take"}, o_trap_take, 0);
    chk({tag, "_mret_take"}, o_mret_take, 0);
    chk({tag, "_cause"}, o_cause, 0);
    chk({tag, "_tval"}, o_tval, 0);
    chk({tag, "_trap_pc"}, o_trap_pc, 0);
    chk({tag, "_rvalid"}, o_redirect_valid, 0);
    chk({tag, "_rpc"}, o_redirect_pc, 0);
  endtask

  // Monitor: compare CSR pulses and redirect handshakes against the scoreboard front.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rst) begin
      if (o_trap_take || o_mret_take) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", {o_trap_take, o_mret_take}, 0);
        end else begin
          e = sb[0];
          chk("trap_take", o_trap_take, !e.is_mret);
          chk("mret_take", o_mret_take, e.is_mret);
          chk("cause", o_cause, e.cause);
          chk("tval", o_tval, e.tval);
          chk("trap_pc", o_trap_pc, e.tpc);
          chk("commit_cycle", cyc, e.commit_cyc);
        end
      end
      if (o_redirect_valid && i_redirect_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_redirect", o_redirect_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("redirect_pc", o_redirect_pc, e.rpc);
          if (e.redir_cyc >= 0) chk("redirect_cycle", cyc, e.redir_cyc);
        end
      end
    end
  end

  task automatic accept(input logic [5:0] ex, input logic intp, input logic mret,
                        input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] bad,
                        input logic exp_mret, input logic [31:0] ecause, input logic [31:0] etval,
                        input logic [31:0] etpc, input logic [31:0] erpc);
    exp_t e;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_ex_vec = ex; i_int_pend = intp; i_mret = mret;
    i_pc = pc; i_inst = inst; i_badaddr = bad;
    e.is_mret = exp_mret; e.cause = ecause; e.tval = etval; e.tpc = etpc; e.rpc = erpc;
    e.commit_cyc = cyc + 1 + (i_pipe_empty ? 1 : DRAIN_MAX);
    e.redir_cyc  = i_redirect_ready ? e.commit_cyc + 1 : -1;
    sb.push_back(e);
    @(negedge i_clk);
    chk("flush_on_accept", o_flush, 1);
    chk("stall_on_accept", o_stall, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ex_vec = '0; i_int_pend = 1'b0; i_mret = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_stall && n < 40);
    chk({tag, "_idle"}, o_stall, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_zero("in_reset");
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    check_zero("after_reset");

    // Illegal instruction: tval is the instruction word.
    accept(6'b000001, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'hDEAD, 1'b0,
           32'd2, 32'hFFFF_FFFF, 32'h100, 32'h200);
    wait_idle("illegal");

    // ecall beats store/load misaligned, interrupt and MRET in the same cycle.
    accept(6'b110100, 1'b1, 1'b1, 32'h104, 32'h73, 32'hBEEF, 1'b0,
           32'd11, 32'd0, 32'h104, 32'h200);
    wait_idle("ecall_prio");

    // Instruction misaligned beats ebreak and store misaligned.
    accept(6'b011010, 1'b0, 1'b0, 32'h108, 32'h0, 32'h10A, 1'b0,
           32'd0, 32'h10A, 32'h108, 32'h200);
    wait_idle("inst_mis");

    accept(6'b001000, 1'b0, 1'b0, 32'h10C, 32'h0, 32'h0, 1'b0,
           32'd3, 32'h10C, 32'h10C, 32'h200);
    wait_idle("ebreak");

    accept(6'b010000, 1'b0, 1'b0, 32'h110, 32'h0, 32'h2002, 1'b0,
           32'd6, 32'h2002, 32'h110, 32'h200);
    wait_idle("st_mis");

    // Vectored timer interrupt: base 0x200 + 4*7.
    i_tvec = 32'h201;
    accept(6'b000000, 1'b1, 1'b0, 32'h114, 32'h0, 32'h55, 1'b0,
           32'h8000_0007, 32'd0, 32'h114, 32'h21C);
    wait_idle("mti");

    // MRET: cause/tval/trap_pc hold the interrupt values.
    i_epc = 32'h403;
    accept(6'b000000, 1'b0, 1'b1, 32'h118, 32'h0, 32'h77, 1'b1,
           32'h8000_0007, 32'd0, 32'h114, 32'h400);
    wait_idle("mret");

    // Pipe never drains: DRAIN_MAX cycles of flush, then fetch stalls the redirect.
    i_tvec = 32'h200;
    i_pipe_empty = 1'b0;
    i_redirect_ready = 1'b0;
    accept(6'b000100, 1'b0, 1'b0, 32'h120, 32'h0, 32'h0, 1'b0,
           32'd11, 32'd0, 32'h120, 32'h200);
    i_valid = 1'b1; i_int_pend = 1'b1; i_ex_vec = 6'b000001;
    for (int i = 0; i < DRAIN_MAX; i++) begin
      @(negedge i_clk);
      chk("drain_flush", o_flush, 1);
      chk("drain_no_pulse", o_trap_take, 0);
    end
    @(negedge i_clk);
    chk("commit_flush_low", o_flush, 0);
    chk("commit_take", o_trap_take, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_int_pend = 1'b0; i_ex_vec = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("hold_valid", o_redirect_valid, 1);
      chk("hold_pc", o_redirect_pc, 32'h200);
    end
    @(posedge i_clk); #1;
    i_redirect_ready = 1'b1;
    wait_idle("drain_max");

    // Reset in the middle of DRAIN abandons the trap with no pulse.
    accept(6'b000001, 1'b0, 1'b0, 32'h124, 32'h1234, 32'h0, 1'b0,
           32'd2, 32'h1234, 32'h124, 32'h200);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    sb.delete();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    check_zero("mid_reset");
    repeat (12) @(negedge i_clk);
    chk("quiet_after_reset", o_stall, 0);
    i_pipe_empty = 1'b1;
    accept(6'b100000, 1'b0, 1'b0, 32'h130, 32'h0, 32'h1001, 1'b0,
           32'd4, 32'h1001, 32'h130, 32'h200);
    wait_idle("ld_mis");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
